// File: rtl/ro_deserializer.sv
// Readout-bus deserializer: collects four 2-bit slots framed by clk_4 into bytes and queues them in a small FIFO.
// Optional RO_PARITY_EN adds a per-entry even-parity output out_par.
module ro_deserializer #(
  parameter int DEPTH = 4
) (
  input  logic       clk_ext,
  input  logic       rstb,
  input  logic       clk_4,
  input  logic       en,
  input  logic [1:0] bus_in,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       ovf,
  input  logic       ovf_clr,
  output logic       sync_err
`ifdef RO_PARITY_EN
  ,
  output logic       out_par
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic             clk_4_d_reg;
  logic [1:0]       slot_reg;
  logic             aligned_reg;
  logic [5:0]       part_reg;
  logic [AW:0]      wptr_reg;
  logic [AW:0]      rptr_reg;
  logic             ovf_reg;
  logic             sync_err_reg;
  logic [7:0]       mem [DEPTH];

  logic             sync;
  logic             frame_done;
  logic [7:0]       frame;
  logic             full;
  logic             not_empty;
  logic             pop;
  logic             push_ok;
  logic             drop;

  assign sync       = clk_4 & ~clk_4_d_reg;
  // Slot 3 completes the frame only on a non-sync cycle; a sync always restarts at slot 0.
  assign frame_done = en & ~sync & aligned_reg & (slot_reg == 2'd3);
  assign frame      = {bus_in, part_reg};

  assign not_empty  = (wptr_reg != rptr_reg);
  assign full       = (wptr_reg[AW] != rptr_reg[AW]) &&
                      (wptr_reg[AW-1:0] == rptr_reg[AW-1:0]);
  assign pop        = not_empty & out_ready;
  assign push_ok    = frame_done & (~full | pop);
  assign drop       = frame_done & full & ~pop;

  // Framing state: slot counter, alignment and partial-frame slots 0..2.
  always_ff @(posedge clk_ext or negedge rstb) begin
    if (!rstb) begin
      clk_4_d_reg  <= 1'b0;
      slot_reg     <= 2'd0;
      aligned_reg  <= 1'b0;
      part_reg     <= 6'd0;
      sync_err_reg <= 1'b0;
    end else begin
      clk_4_d_reg  <= clk_4;
      sync_err_reg <= 1'b0;
      if (!en) begin
        aligned_reg <= 1'b0;
        slot_reg    <= 2'd0;
      end else if (sync) begin
        sync_err_reg  <= aligned_reg & (slot_reg != 2'd0);
        aligned_reg   <= 1'b1;
        part_reg[1:0] <= bus_in;
        slot_reg      <= 2'd1;
      end else if (aligned_reg) begin
        case (slot_reg)
          2'd0:    part_reg[1:0] <= bus_in;
          2'd1:    part_reg[3:2] <= bus_in;
          2'd2:    part_reg[5:4] <= bus_in;
          default: ;
        endcase
        slot_reg <= slot_reg + 2'd1;
      end
    end
  end

  // FIFO pointers and sticky overflow; a drop takes precedence over ovf_clr.
  always_ff @(posedge clk_ext or negedge rstb) begin
    if (!rstb) begin
      wptr_reg <= '0;
      rptr_reg <= '0;
      ovf_reg  <= 1'b0;
    end else begin
      if (push_ok) wptr_reg <= wptr_reg + (AW+1)'(1);
      if (pop)     rptr_reg <= rptr_reg + (AW+1)'(1);
      if (drop)         ovf_reg <= 1'b1;
      else if (ovf_clr) ovf_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk_ext) begin
    if (push_ok) mem[wptr_reg[AW-1:0]] <= frame;
  end

  assign out_valid = not_empty;
  assign out_data  = not_empty ? mem[rptr_reg[AW-1:0]] : 8'h00;
  assign ovf       = ovf_reg;
  assign sync_err  = sync_err_reg;

`ifdef RO_PARITY_EN
  logic par_mem [DEPTH];

  always_ff @(posedge clk_ext) begin
    if (push_ok) par_mem[wptr_reg[AW-1:0]] <= ^frame;
  end

  assign out_par = not_empty ? par_mem[rptr_reg[AW-1:0]] : 1'b0;
`endif

endmodule
